lc3b_rob: RTL

- 8-entry circular reorder buffer for the LC-3b Tomasulo core.
- Sits between the common data bus (CDB) and the architectural register file (regfile_t entries).
- Dispatch allocates an entry and receives its ROB tag, which is renamed into regfile_t.rob_entry.
- Functional units broadcast results on the CDB. The ROB captures them and retires entries in program order, one per cycle, to the register file.

---
 rtl/lc3b_rob.sv | 135 +++++++++++++
 1 files changed

// File: rtl/lc3b_rob.sv
// 8-entry circular reorder buffer: CDB capture, in-order single-issue commit to the regfile.
// Optional same-cycle CDB forwarding to lookups and commit: define ROB_CDB_BYPASS_EN.
package lc3b_rob_pkg;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CDB_TAG_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [DATA_W-1:0]    data;
    logic [CDB_TAG_W-1:0] tag;
  } cdb_t;
endpackage

module lc3b_rob
  import lc3b_rob_pkg::*;
#(
  parameter int unsigned TAG_W = 3,
  parameter int unsigned DEPTH = 2 ** TAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc_req,
  input  logic [2:0]        alloc_dest,
  input  logic              alloc_regwrite,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              full,
  output logic              empty,
  input  cdb_t              cdb_in,
  input  logic [TAG_W-1:0]  rd_tag_a,
  output logic              rd_ready_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [TAG_W-1:0]  rd_tag_b,
  output logic              rd_ready_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [2:0]        commit_dest,
  output logic              commit_regwrite,
  output logic [DATA_W-1:0] commit_data
);

  localparam int unsigned CNT_W = TAG_W + 1;

`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  ready_q;
  logic [DEPTH-1:0]  regwrite_q;
  logic [2:0]        dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]  head_q;
  logic [TAG_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic alloc_fire;
  logic capture_fire;
  logic byp_a;
  logic byp_b;
  logic byp_head;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign alloc_tag = tail_q;

  assign alloc_fire   = alloc_req & ~full & ~flush;
  assign capture_fire = cdb_in.valid & valid_q[cdb_in.tag] & ~ready_q[cdb_in.tag] & ~flush;

  // Forwarding hits: a broadcast in flight to the looked-up entry
  assign byp_a    = BYPASS & cdb_in.valid & (cdb_in.tag == rd_tag_a);
  assign byp_b    = BYPASS & cdb_in.valid & (cdb_in.tag == rd_tag_b);
  assign byp_head = BYPASS & cdb_in.valid & (cdb_in.tag == head_q);

  always_comb begin
    rd_ready_a = valid_q[rd_tag_a] & (ready_q[rd_tag_a] | byp_a);
    rd_data_a  = (byp_a && !ready_q[rd_tag_a]) ? cdb_in.data : data_q[rd_tag_a];
    rd_ready_b = valid_q[rd_tag_b] & (ready_q[rd_tag_b] | byp_b);
    rd_data_b  = (byp_b && !ready_q[rd_tag_b]) ? cdb_in.data : data_q[rd_tag_b];
  end

  // Head retirement; a pending flush squashes it
  always_comb begin
    commit_valid    = valid_q[head_q] & (ready_q[head_q] | byp_head) & ~flush;
    commit_tag      = head_q;
    commit_dest     = dest_q[head_q];
    commit_regwrite = commit_valid & regwrite_q[head_q];
    commit_data     = (byp_head && !ready_q[head_q]) ? cdb_in.data : data_q[head_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      ready_q    <= '0;
      regwrite_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (capture_fire) begin
        data_q[cdb_in.tag]  <= cdb_in.data;
        ready_q[cdb_in.tag] <= 1'b1;
      end
      // Commit clear follows capture so a forwarded head retires cleanly
      if (commit_valid) begin
        valid_q[head_q] <= 1'b0;
        ready_q[head_q] <= 1'b0;
        head_q          <= TAG_W'(head_q + 1'b1);
      end
      if (alloc_fire) begin
        valid_q[tail_q]    <= 1'b1;
        ready_q[tail_q]    <= 1'b0;
        regwrite_q[tail_q] <= alloc_regwrite;
        dest_q[tail_q]     <= alloc_dest;
        data_q[tail_q]     <= '0;
        tail_q             <= TAG_W'(tail_q + 1'b1);
      end
      count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(commit_valid);
    end
  end

endmodule
